// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two requesters,
// with operand latching, multi-cycle MUL sequencing and a buffered tagged response.
module alu_share_arbiter #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*DATA_W-1:0] req_src1_i,
    input  logic [2*DATA_W-1:0] req_src2_i,
    input  logic [2*CTRL_W-1:0] req_ctrl_i,
    output logic [DATA_W-1:0]   alu_src1_o,
    output logic [DATA_W-1:0]   alu_src2_o,
    output logic [CTRL_W-1:0]   alu_ctrl_o,
    input  logic [DATA_W-1:0]   alu_result_i,
    input  logic                alu_zero_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_id_o,
    output logic [DATA_W-1:0]   rsp_result_o,
    output logic                rsp_zero_o
);
    // state | meaning
    // IDLE  | arbitrate between valid requesters, accept one op
    // EXEC  | operands held on ALU, counting down execution cycles
    // RESP  | result buffered, waiting for consumer ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int CNT_W = (MUL_CYCLES < 2) ? 1 : $clog2(MUL_CYCLES + 1);
    localparam logic [CTRL_W-1:0] CTRL_MUL = CTRL_W'(3);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              id_q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              accept;
    logic              grant_idx;
    logic [DATA_W-1:0] sel_src1, sel_src2;
    logic [CTRL_W-1:0] sel_ctrl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Ready is masked during reset so the grant is zero immediately.
    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst_i) begin
                    case (req_valid_i)
                        2'b01:   grant = 2'b01;
                        2'b10:   grant = 2'b10;
                        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                        default: grant = 2'b00;
                    endcase
                end
                if (|(req_valid_i & grant)) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP: if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready_o = grant;
    assign grant_idx   = grant[1];
    assign sel_src1    = grant_idx ? req_src1_i[2*DATA_W-1:DATA_W] : req_src1_i[DATA_W-1:0];
    assign sel_src2    = grant_idx ? req_src2_i[2*DATA_W-1:DATA_W] : req_src2_i[DATA_W-1:0];
    assign sel_ctrl    = grant_idx ? req_ctrl_i[2*CTRL_W-1:CTRL_W] : req_ctrl_i[CTRL_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            alu_ctrl_o   <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            id_q         <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
        end else begin
            if (accept) begin
                alu_src1_o <= sel_src1;
                alu_src2_o <= sel_src2;
                alu_ctrl_o <= sel_ctrl;
                id_q       <= grant_idx;
                last_grant <= grant_idx;
                cnt        <= (sel_ctrl == CTRL_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(1);
            end
            if (state == EXEC) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rsp_result_o <= alu_result_i;
                    rsp_zero_o   <= alu_zero_i;
                    rsp_id_o     <= id_q;
                    rsp_valid_o  <= 1'b1;
                end
            end
            if (state == RESP && rsp_ready_i) rsp_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random rounds checked
// against a transaction-level model of arbitration, latency and ALU arithmetic.
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int MC = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_src1 = '0;
    logic [2*DW-1:0] req_src2 = '0;
    logic [2*CW-1:0] req_ctrl = '0;
    logic [DW-1:0]   alu_src1, alu_src2, alu_result;
    logic [CW-1:0]   alu_ctrl;
    logic            alu_zero;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [DW-1:0]   rsp_result;
    logic            rsp_zero;

    int total = 0;
    int bad   = 0;

    bit [1:0]        pend;
    logic [DW-1:0]   op_a [2];
    logic [DW-1:0]   op_b [2];
    logic [CW-1:0]   op_c [2];
    int              last_g;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW), .MUL_CYCLES(MC)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_src1_i(req_src1), .req_src2_i(req_src2), .req_ctrl_i(req_ctrl),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero)
    );

    function automatic logic [DW-1:0] ref_alu(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a * b;
            4'd6:    return a - b;
            default: return '0;
        endcase
    endfunction

    // External ALU the arbiter feeds
    assign alu_result = ref_alu(alu_ctrl, alu_src1, alu_src2);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = pend;
        req_src1  = {op_a[1], op_a[0]};
        req_src2  = {op_b[1], op_b[0]};
        req_ctrl  = {op_c[1], op_c[0]};
    endtask

    task automatic set_req(input int r, input logic [CW-1:0] c, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        pend[r] = 1'b1;
        op_c[r] = c;
        op_a[r] = a;
        op_b[r] = b;
    endtask

    task automatic rand_req(input int r);
        logic [CW-1:0] c;
        logic [DW-1:0] a, b;
        case ($urandom_range(5, 0))
            0: c = 4'd0;
            1: c = 4'd1;
            2: c = 4'd2;
            3: c = 4'd3;
            4: c = 4'd6;
            default: c = 4'($urandom);
        endcase
        a = $urandom;
        b = ($urandom_range(3, 0) == 0) ? a : DW'($urandom);
        set_req(r, c, a, b);
    endtask

    // One full transaction: grant, EXEC latency, response, optional stall, handshake.
    task automatic run_round(input int stall);
        int            g, k;
        logic [DW-1:0] ea, eb, er;
        logic [CW-1:0] ec;
        drive();
        #1;
        if (pend[0] && pend[1]) g = (last_g == 1) ? 0 : 1;
        else                    g = pend[0] ? 0 : 1;
        chk("grant", 64'(req_ready), 64'(2'b01 << g));
        ea = op_a[g]; eb = op_b[g]; ec = op_c[g];
        er = ref_alu(ec, ea, eb);
        k  = (ec == 4'd3) ? MC : 1;
        @(posedge clk); #1;
        last_g  = g;
        pend[g] = 1'b0;
        drive();
        #1;
        chk("alu_src1", 64'(alu_src1), 64'(ea));
        chk("alu_src2", 64'(alu_src2), 64'(eb));
        chk("alu_ctrl", 64'(alu_ctrl), 64'(ec));
        chk("ready_exec", 64'(req_ready), 64'(0));
        for (int i = 1; i < k; i++) begin
            @(posedge clk); #1;
            chk("rsp_early", 64'(rsp_valid), 64'(0));
            chk("alu_hold", 64'({alu_ctrl, alu_src1, alu_src2}), 64'({ec, ea, eb}));
        end
        @(posedge clk); #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_id", 64'(rsp_id), 64'(g));
        chk("rsp_result", 64'(rsp_result), 64'(er));
        chk("rsp_zero", 64'(rsp_zero), 64'(er == '0));
        if (stall > 0 && !pend[g]) begin
            rand_req(g);
            drive();
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", 64'({rsp_valid, rsp_id, rsp_zero, rsp_result}),
                64'({1'b1, 1'(g), er == '0, er}));
            chk("ready_resp", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_clear", 64'(rsp_valid), 64'(0));
        chk("rsp_retain", 64'(rsp_result), 64'(er));
    endtask

    initial begin
        pend   = '0;
        last_g = 1;
        for (int r = 0; r < 2; r++) begin
            op_a[r] = '0; op_b[r] = '0; op_c[r] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(0));

        // both valid after reset: req0 wins the first tie
        set_req(0, 4'd6, 32'd9, 32'd9);
        set_req(1, 4'd1, 32'hF0, 32'h0F);
        run_round(0);
        run_round(0);
        set_req(0, 4'd2, 32'd5, 32'd7);
        run_round(0);
        set_req(1, 4'd3, 32'd6, 32'd7);
        run_round(0);
        // long stall in RESP with both requesters waiting
        set_req(0, 4'd2, 32'd1, 32'd2);
        set_req(1, 4'd0, 32'hFF, 32'h3C);
        run_round(5);
        run_round(0);
        if (pend != 2'b00) run_round(0);

        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(1, 0) == 1) rand_req(r);
            if (pend == 2'b00) rand_req(int'($urandom_range(1, 0)));
            run_round(($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0);
        end

        // reset in the middle of a MUL
        pend = '0;
        set_req(1, 4'd3, 32'd6, 32'd7);
        drive();
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_req(0, 4'd2, 32'd1, 32'd1);
        drive();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        chk("mid_rst_alu", 64'({alu_ctrl, alu_src1, alu_src2}), 64'(0));
        chk("mid_rst_rsp", 64'({rsp_valid, rsp_id, rsp_zero, rsp_result}), 64'(0));
        pend = '0;
        drive();
        @(posedge clk); #1;
        rst    = 1'b0;
        last_g = 1;
        set_req(0, 4'd0, 32'hC, 32'hA);
        run_round(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
